// File: rtl/rectangle128_stream_adapter.sv
// rectangle128_stream_adapter
// Bridges a 32-bit valid/ready stream to the 64-bit RECTANGLE128 core
// interface. It packs two input words into one plaintext block, runs the
// core under a watchdog, and unpacks the 64-bit result into two output
// words. Only one block is in flight at any time.
module rectangle128_stream_adapter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             core_enable,
    output logic             core_encrypt,
    output logic [63:0]      core_plaintext,
    input  logic [63:0]      core_ciphertext,
    input  logic             core_ready,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic [CNT_W-1:0] blk_count
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALF   = 3'd1,
        S_RUN    = 3'd2,
        S_OUT_HI = 3'd3,
        S_OUT_LO = 3'd4
    } state_t;

    state_t          state_r;
    logic [31:0]     pt_hi_r;
    logic            mode_r;
    logic [63:0]     res_r;
    logic [WD_W-1:0] wdog_r;

    logic            capture_s;
    logic            timeout_s;

    // Decode RUN events; the first RUN cycle (wdog 0) ignores a possibly stale core_ready,
    // and a ready arriving on the last watchdog cycle beats the timeout.
    always_comb begin
        capture_s = 1'b0;
        timeout_s = 1'b0;
        if (state_r == S_RUN) begin
            capture_s = (wdog_r != '0) && core_ready;
            timeout_s = !capture_s && (wdog_r == WD_LAST);
        end else begin
            capture_s = 1'b0;
            timeout_s = 1'b0;
        end
    end

    // The input side accepts words only while collecting a block.
    assign in_ready = (state_r == S_IDLE) || (state_r == S_HALF);
    assign busy     = (state_r != S_IDLE);

    // Block sequencer: packing, core handshake with watchdog, and output unpacking.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r        <= S_IDLE;
            pt_hi_r        <= 32'd0;
            mode_r         <= 1'b0;
            res_r          <= 64'd0;
            wdog_r         <= '0;
            out_data       <= 32'd0;
            out_valid      <= 1'b0;
            core_enable    <= 1'b0;
            core_encrypt   <= 1'b0;
            core_plaintext <= 64'd0;
            blk_count      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        pt_hi_r <= in_data;
                        mode_r  <= in_mode;
                        state_r <= S_HALF;
                    end
                end
                S_HALF: begin
                    if (in_valid) begin
                        core_plaintext <= {pt_hi_r, in_data};
                        core_encrypt   <= mode_r;
                        core_enable    <= 1'b1;
                        wdog_r         <= '0;
                        state_r        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (capture_s) begin
                        res_r       <= core_ciphertext;
                        out_data    <= core_ciphertext[63:32];
                        out_valid   <= 1'b1;
                        core_enable <= 1'b0;
                        state_r     <= S_OUT_HI;
                    end else if (timeout_s) begin
                        core_enable <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                S_OUT_HI: begin
                    if (out_ready) begin
                        out_data <= res_r[31:0];
                        state_r  <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_count <= blk_count + CNT_W'(1);
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid   <= 1'b0;
                    core_enable <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout takes priority over a clear in the same cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_timeout <= 1'b0;
        end else if (timeout_s) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= err_timeout;
        end
    end

endmodule

// File: tb/tb_rectangle128_stream_adapter.sv
// Bench for rectangle128_stream_adapter: directed blocks, a simple core
// stand-in, and a block-level reference model compared every cycle.
module tb_rectangle128_stream_adapter;

    localparam int T  = 8;
    localparam int CW = 2;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          core_enable;
    logic          core_encrypt;
    logic [63:0]   core_plaintext;
    logic [63:0]   core_ciphertext;
    logic          core_ready;
    logic          busy;
    logic          err_timeout;
    logic          err_clr;
    logic [CW-1:0] blk_count;

    rectangle128_stream_adapter #(.TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_enable(core_enable), .core_encrypt(core_encrypt),
        .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext),
        .core_ready(core_ready), .busy(busy), .err_timeout(err_timeout),
        .err_clr(err_clr), .blk_count(blk_count)
    );

    initial forever #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // Stand-in core result function (not the real cipher except for the zero vector).
    function automatic logic [63:0] cfun(input logic [63:0] pt, input logic enc);
        if (enc && pt == 64'h0) return 64'h2D96_E354_E8B1_0874;
        if (enc) return {pt[31:0] ^ 32'h5A5A_0F0F, pt[63:32] + 32'h1234_5678};
        return ~pt ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Core environment knobs
    int core_lat   = 5;
    bit core_never = 1'b0;
    bit core_hold  = 1'b0;
    int core_k     = 0;

    // Core stand-in: ready after core_lat enabled cycles; hold mode keeps ready high
    // throughout and presents junk data in the first enabled cycle.
    initial begin
        core_ready      = 1'b0;
        core_ciphertext = 64'h0;
        forever begin
            @(posedge Clk);
            #1;
            if (core_enable) core_k++;
            else core_k = 0;
            core_ready = core_hold || (core_enable && !core_never && core_k >= core_lat);
            if (core_enable && !(core_hold && core_k == 1))
                core_ciphertext = cfun(core_plaintext, core_encrypt);
            else
                core_ciphertext = 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // Block-level model state
    bit            m_active = 1'b0;
    int            m_rc     = 0;
    int            m_eff    = 0;
    int            m_wi     = 0;
    logic [31:0]   m_hi     = 32'h0;
    logic          m_mode   = 1'b0;
    logic [63:0]   m_pt     = 64'h0;
    logic [31:0]   m_q[$];
    int            m_pend   = 0;
    logic          m_err    = 1'b0;
    logic [CW-1:0] m_cnt    = '0;
    logic [31:0]   got[$];
    int            cur_en   = 0;
    int            last_en  = 0;

    // Cycle on which the core's answer is taken (0 = never within reach).
    function automatic int eff_cycle();
        if (core_hold) return 2;
        if (core_never) return 0;
        return (core_lat < 2) ? 2 : core_lat;
    endfunction

    // Compare process: mid-cycle sample of the DUT against the model, then advance the model.
    initial begin
        logic [63:0] c;
        bit rdy;
        bit ok_blk;
        bit set_now;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                m_active = 1'b0; m_wi = 0; m_pend = 0; m_err = 1'b0; m_cnt = '0;
                m_q.delete();
                cur_en = 0;
                chk("rst_core_enable", 64'(core_enable), 64'h0);
                chk("rst_busy", 64'(busy), 64'h0);
                chk("rst_out_valid", 64'(out_valid), 64'h0);
                chk("rst_out_data", 64'(out_data), 64'h0);
                chk("rst_err", 64'(err_timeout), 64'h0);
                chk("rst_blk_count", 64'(blk_count), 64'h0);
                chk("rst_plaintext", core_plaintext, 64'h0);
                chk("rst_encrypt", 64'(core_encrypt), 64'h0);
            end else begin
                if (m_active) m_rc++;
                rdy = !m_active && (m_pend == 0);
                chk("in_ready", 64'(in_ready), 64'(rdy));
                chk("busy", 64'(busy), 64'((m_wi == 1) || m_active || (m_pend > 0)));
                chk("core_enable", 64'(core_enable), 64'(m_active));
                if (m_active) begin
                    chk("core_encrypt", 64'(core_encrypt), 64'(m_mode));
                    chk("core_plaintext", core_plaintext, m_pt);
                end
                chk("out_valid", 64'(out_valid), 64'(m_pend > 0));
                if (m_pend > 0 && m_q.size() > 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
                chk("err_timeout", 64'(err_timeout), 64'(m_err));
                chk("blk_count", 64'(blk_count), 64'(m_cnt));

                if (core_enable) cur_en++;
                else if (cur_en > 0) begin last_en = cur_en; cur_en = 0; end

                if (m_pend > 0 && out_ready) begin
                    got.push_back(out_data);
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    m_pend--;
                    if (m_pend == 0) m_cnt = m_cnt + {{(CW-1){1'b0}}, 1'b1};
                end

                set_now = 1'b0;
                if (m_active && m_rc > 0) begin
                    ok_blk = (m_eff != 0) && (m_eff <= T);
                    if (ok_blk && m_rc == m_eff) begin
                        m_active = 1'b0;
                        c = cfun(m_pt, m_mode);
                        m_q.push_back(c[63:32]);
                        m_q.push_back(c[31:0]);
                        m_pend = 2;
                    end else if (!ok_blk && m_rc == T) begin
                        m_active = 1'b0;
                        m_err = 1'b1;
                        set_now = 1'b1;
                    end
                end
                if (!set_now && err_clr) m_err = 1'b0;

                if (rdy && in_valid) begin
                    if (m_wi == 0) begin
                        m_hi = in_data; m_mode = in_mode; m_wi = 1;
                    end else begin
                        m_pt = {m_hi, in_data}; m_wi = 0;
                        m_active = 1'b1; m_rc = 0; m_eff = eff_cycle();
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] d, input logic m);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("send_word");
        @(posedge Clk); #1;
        in_valid = 1'b0; in_data = 32'hFFFF_FFFF; in_mode = ~m;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("wait_idle");
        @(posedge Clk); #1;
    endtask

    task automatic wait_out_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("wait_out_valid");
        @(posedge Clk); #1;
    endtask

    int seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        Rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_mode = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick(3);
        chk("reset_enable", 64'(core_enable), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_blk_count", 64'(blk_count), 64'h0);
        Rst = 1'b0;
        tick(1);

        // Encrypt zero block, back-to-back words, core latency 5
        out_ready = 1'b1; core_lat = 5;
        send_word(32'h0000_0000, 1'b1);
        send_word(32'h0000_0000, 1'b0);
        wait_idle(60);
        chk("t1_n_words", 64'(got.size()), 64'd2);
        chk("t1_word_hi", 64'(got[0]), 64'h2D96_E354);
        chk("t1_word_lo", 64'(got[1]), 64'hE8B1_0874);
        chk("t1_blk_count", 64'(blk_count), 64'd1);
        chk("t1_enable_cycles", 64'(last_en), 64'd5);

        // Output backpressure for 10 cycles in OUT_HI
        out_ready = 1'b0; core_lat = 3;
        send_word(32'h0123_4567, 1'b1);
        send_word(32'h89AB_CDEF, 1'b0);
        wait_out_valid(60);
        tick(10);
        chk("t2_held_data", 64'(out_data), 64'hD3F1_C2E0);
        chk("t2_held_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        wait_idle(60);
        chk("t2_word_hi", 64'(got[2]), 64'hD3F1_C2E0);
        chk("t2_word_lo", 64'(got[3]), 64'h1357_9BDF);
        chk("t2_blk_count", 64'(blk_count), 64'd2);

        // Watchdog timeout, then clear
        core_never = 1'b1;
        send_word(32'h1111_1111, 1'b1);
        send_word(32'h2222_2222, 1'b1);
        wait_idle(60);
        chk("t3_err_set", 64'(err_timeout), 64'h1);
        chk("t3_no_output", 64'(got.size()), 64'd4);
        chk("t3_enable_cycles", 64'(last_en), 64'd8);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("t3_err_cleared", 64'(err_timeout), 64'h0);

        // Timeout and err_clr on the same edge: set wins
        send_word(32'h3333_3333, 1'b1);
        send_word(32'h4444_4444, 1'b1);
        tick(T - 1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("t3b_set_wins", 64'(err_timeout), 64'h1);
        wait_idle(20);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("t3b_cleared", 64'(err_timeout), 64'h0);
        core_never = 1'b0;

        // Stale ready held high entering RUN
        core_hold = 1'b1; core_lat = 20;
        send_word(32'hAAAA_5555, 1'b1);
        send_word(32'h0F0F_F0F0, 1'b1);
        wait_idle(60);
        chk("t4_enable_cycles", 64'(last_en), 64'd2);
        chk("t4_word_hi", 64'(got[4]), 64'h5555_FFFF);
        chk("t4_word_lo", 64'(got[5]), 64'hBCDE_ABCD);
        core_hold = 1'b0;

        // Ready on the final watchdog cycle beats the timeout
        core_lat = T;
        send_word(32'h0000_FFFF, 1'b0);
        send_word(32'hFFFF_0000, 1'b0);
        wait_idle(60);
        chk("t4b_err", 64'(err_timeout), 64'h0);
        chk("t4b_enable_cycles", 64'(last_en), 64'd8);
        chk("t4b_word_hi", 64'(got[6]), 64'hFEDC_4567);
        chk("t4b_word_lo", 64'(got[7]), 64'h89AB_3210);
        chk("t4b_blk_wrap", 64'(blk_count), 64'd0);

        // Reset during RUN drops everything at once
        core_lat = 6;
        send_word(32'h5555_5555, 1'b1);
        send_word(32'h6666_6666, 1'b1);
        tick(2);
        Rst = 1'b1;
        #1;
        chk("t5_async_enable", 64'(core_enable), 64'h0);
        chk("t5_async_busy", 64'(busy), 64'h0);
        chk("t5_async_plaintext", core_plaintext, 64'h0);
        tick(2);
        Rst = 1'b0;
        tick(1);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'h0123_4567, 1'b1);
        chk("t5_dec_enable", 64'(core_enable), 64'h1);
        chk("t5_dec_encrypt", 64'(core_encrypt), 64'h0);
        wait_idle(60);
        chk("t5_word_hi", 64'(got[8]), 64'h2071_0477);
        chk("t5_word_lo", 64'(got[9]), 64'h7777_7777);
        chk("t5_blk_count", 64'(blk_count), 64'd1);

        // Counter wrap from a clean reset
        Rst = 1'b1; tick(2); Rst = 1'b0; tick(1);
        core_lat = 2;
        for (int i = 0; i < 5; i++) begin
            send_word(32'(i), 1'b1);
            send_word(~32'(i), 1'b1);
            wait_idle(60);
            chk("t6_blk_count", 64'(blk_count), 64'(seq[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
